ioctl_upload_rd: RTL and testbench

- HPS upload responder: reads bytes out of a core-side byte RAM and returns them over the ioctl upload channel. Covers save RAM and cartridge RAM dumps.
- Mirror of the ioctl download write path: the HPS drives address and read strobes, and this block answers with data, stalling the HPS through ioctl_wait.
- Sits between hps_io and a byte-wide RAM port, which it shares with the core through a req/gnt arbiter.

---
 rtl/ioctl_upload_rd.sv | 184 ++++++++++++++++++
 tb/tb_ioctl_upload_rd.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_rd.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_upload_rd
// Purpose  : HPS upload responder. Answers ioctl upload read strobes with
//            bytes fetched from a core-side byte RAM (save RAM, cartridge
//            RAM dumps). The RAM port is shared with the core through a
//            req/gnt handshake; the HPS is held off with ioctl_wait while a
//            fetch is outstanding.
// Ports    :
//   clk_sys       system clock, rising edge
//   reset_n       asynchronous active-low reset
//   ioctl_upload  upload session active (level)
//   ioctl_rd      one-cycle read strobe for the byte at ioctl_addr
//   ioctl_addr    25-bit byte address
//   ioctl_din     returned byte (valid from the cycle ioctl_wait falls)
//   ioctl_wait    fetch pending, HPS must not issue another strobe
//   mem_req       RAM access request, held until granted
//   mem_gnt       RAM grant; access occurs on edge with mem_req & mem_gnt
//   mem_addr      RAM byte address, stable while mem_req is high
//   mem_q         RAM read data, valid RD_LAT edges after the grant edge
//   byte_cnt      bytes served in the current session (wraps mod 2^25)
//   upload_done   one-cycle pulse when the session ends
// Revision : 1.0 - initial release
// ============================================================================
module ioctl_upload_rd #(
    parameter int          AW       = 16,
    parameter int          MEM_SIZE = 65536,
    parameter int          RD_LAT   = 2,
    parameter logic [7:0]  FILL     = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic [24:0]   byte_cnt,
    output logic          upload_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LAT  = 2'd2
    } state_t;

    // One extra bit so MEM_SIZE up to 2^25 is representable and the compare
    // covers the full address without aliasing upper bits into the RAM.
    localparam logic [25:0] c_mem_size = 26'(MEM_SIZE);
    localparam logic [2:0]  c_rd_lat   = 3'(RD_LAT);

    state_t          state_q, state_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic            upload_q, upload_d;
    logic [7:0]      ioctl_din_q, ioctl_din_d;
    logic            ioctl_wait_q, ioctl_wait_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [24:0]     byte_cnt_q, byte_cnt_d;
    logic            upload_done_q, upload_done_d;

    logic            upload_rise;
    logic            upload_fall;
    logic            addr_in_range;

    assign upload_rise   = ioctl_upload & ~upload_q;
    assign upload_fall   = ~ioctl_upload & upload_q;
    assign addr_in_range = ({1'b0, ioctl_addr} < c_mem_size);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        upload_d      = ioctl_upload;
        ioctl_din_d   = ioctl_din_q;
        ioctl_wait_d  = ioctl_wait_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        byte_cnt_d    = byte_cnt_q;
        upload_done_d = upload_fall;

        // A new session restarts the count; a strobe accepted on the same
        // edge then counts as the first byte of that session.
        if (upload_rise) begin
            byte_cnt_d = '0;
        end

        if (upload_fall) begin
            // Session ended: drop any outstanding fetch. A read already
            // issued to the RAM is simply never sampled.
            state_d      = ST_IDLE;
            mem_req_d    = 1'b0;
            ioctl_wait_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ioctl_rd && ioctl_upload) begin
                        if (addr_in_range) begin
                            mem_addr_d   = ioctl_addr[AW-1:0];
                            mem_req_d    = 1'b1;
                            ioctl_wait_d = 1'b1;
                            state_d      = ST_REQ;
                        end else begin
                            // Out-of-range bytes are answered immediately
                            // without touching the RAM or stalling the HPS.
                            ioctl_din_d = FILL;
                            byte_cnt_d  = byte_cnt_d + 25'd1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem_req_q && mem_gnt) begin
                        mem_req_d = 1'b0;
                        lat_cnt_d = 3'd1;
                        state_d   = ST_LAT;
                    end
                end

                ST_LAT: begin
                    // lat_cnt_q equals the number of edges since the grant
                    // edge, so reaching RD_LAT means mem_q is valid now.
                    if (lat_cnt_q == c_rd_lat) begin
                        ioctl_din_d  = mem_q;
                        ioctl_wait_d = 1'b0;
                        byte_cnt_d   = byte_cnt_d + 25'd1;
                        state_d      = ST_IDLE;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end

                default: begin
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    ioctl_wait_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            lat_cnt_q     <= 3'd0;
            upload_q      <= 1'b0;
            ioctl_din_q   <= 8'h00;
            ioctl_wait_q  <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            byte_cnt_q    <= 25'd0;
            upload_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            upload_q      <= upload_d;
            ioctl_din_q   <= ioctl_din_d;
            ioctl_wait_q  <= ioctl_wait_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            byte_cnt_q    <= byte_cnt_d;
            upload_done_q <= upload_done_d;
        end
    end

    assign ioctl_din   = ioctl_din_q;
    assign ioctl_wait  = ioctl_wait_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign byte_cnt    = byte_cnt_q;
    assign upload_done = upload_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_upload_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ioctl_upload_rd
// Purpose  : Self-checking bench for ioctl_upload_rd with a two-stage RAM
//            model (RD_LAT=2) whose data is only valid in the cycle before
//            the sampling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ioctl_upload_rd;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_q;
    logic [24:0] byte_cnt;
    logic        upload_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_rd #(
        .AW       (16),
        .MEM_SIZE (65536),
        .RD_LAT   (2),
        .FILL     (8'hFF)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_addr     (mem_addr),
        .mem_q        (mem_q),
        .byte_cnt     (byte_cnt),
        .upload_done  (upload_done)
    );

    // RAM contents: byte = lo + hi + 0x11, except 0x0123 holds 0x5A.
    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        if (a == 16'h0123) return 8'h5A;
        return a[7:0] + a[15:8] + 8'h11;
    endfunction

    // Grant edge G captures the address, G+1 reads, data valid until G+2.
    logic [15:0] s1_addr = '0;
    logic        s1_v    = 1'b0;
    logic        q_v     = 1'b0;
    logic [7:0]  q_data  = '0;
    always @(posedge clk_sys) begin
        s1_v    <= mem_req && mem_gnt;
        s1_addr <= mem_addr;
        q_v     <= s1_v;
        q_data  <= ram_rd(s1_addr);
    end
    assign mem_q = q_v ? q_data : 8'hEE;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with ioctl_wait low.
    task automatic do_read(input logic [24:0] a, output int wait_cyc,
                           output int req_cyc, output logic addr_ok);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        wait_cyc = 0;
        req_cyc  = 0;
        addr_ok  = 1'b1;
        while (ioctl_wait && wait_cyc < 64) begin
            if (mem_req) begin
                req_cyc++;
                if (mem_addr !== a[15:0]) addr_ok = 1'b0;
            end
            wait_cyc++;
            @(negedge clk_sys);
        end
    endtask

    typedef struct {
        logic [24:0] addr;
        logic        in_range;
        logic [7:0]  din;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   wc, rc, exp_cnt, hi_cnt, n;
        logic aok, flag;
        logic [15:0] held;

        vecs[0] = '{25'h0000123, 1'b1, 8'h5A};
        vecs[1] = '{25'h0000000, 1'b1, 8'h11};
        vecs[2] = '{25'h000FFFF, 1'b1, 8'h0F};
        vecs[3] = '{25'h0010000, 1'b0, 8'hFF};
        vecs[4] = '{25'h0001234, 1'b1, 8'h57};
        vecs[5] = '{25'h1FFFFFF, 1'b0, 8'hFF};
        vecs[6] = '{25'h1000123, 1'b0, 8'hFF};
        vecs[7] = '{25'h000ABCD, 1'b1, 8'h89};

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        mem_gnt      = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("reset_outputs",
            {ioctl_din, ioctl_wait, mem_req, mem_addr, byte_cnt, upload_done}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Strobe without a session is ignored.
        ioctl_addr = 25'h10000;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("no_session_ignored", {ioctl_din, ioctl_wait, mem_req, byte_cnt}, 32'h0);

        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        exp_cnt = 0;

        // Table of single reads
        for (int i = 0; i < 8; i++) begin
            do_read(vecs[i].addr, wc, rc, aok);
            exp_cnt++;
            chk($sformatf("v%0d_wait_cycles", i), wc, vecs[i].in_range ? 3 : 0);
            chk($sformatf("v%0d_req_cycles", i), rc, vecs[i].in_range ? 1 : 0);
            chk($sformatf("v%0d_mem_addr", i), aok, 1);
            chk($sformatf("v%0d_din", i), ioctl_din, vecs[i].din);
            chk($sformatf("v%0d_byte_cnt", i), byte_cnt, exp_cnt);
            @(negedge clk_sys);
        end

        // Arbitration stall
        mem_gnt    = 1'b0;
        ioctl_addr = 25'h00AB;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        held = mem_addr;
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(mem_req && ioctl_wait && mem_addr == held)) flag = 1'b0;
            @(negedge clk_sys);
        end
        chk("stall_hold", {flag, held}, {1'b1, 16'h00AB});
        mem_gnt = 1'b1;
        @(negedge clk_sys);
        chk("stall_req_drop", mem_req, 0);
        hi_cnt = 0;
        while (ioctl_wait && hi_cnt < 64) begin
            hi_cnt++;
            @(negedge clk_sys);
        end
        exp_cnt++;
        chk("stall_wait_after_grant", hi_cnt, 2);
        chk("stall_din", ioctl_din, 8'hBC);
        chk("stall_byte_cnt", byte_cnt, exp_cnt);
        @(negedge clk_sys);

        // Abort in LAT
        ioctl_addr = 25'h1234;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("abort_in_lat", {ioctl_wait, mem_req}, 2'b10);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("abort_wait", ioctl_wait, 0);
        chk("abort_done_pulse", upload_done, 1);
        chk("abort_byte_cnt", byte_cnt, exp_cnt);
        chk("abort_din_kept", ioctl_din, 8'hBC);
        @(negedge clk_sys);
        chk("abort_done_one_cycle", upload_done, 0);
        repeat (3) @(negedge clk_sys);
        chk("abort_discard", {ioctl_din, ioctl_wait, mem_req}, {8'hBC, 2'b00});
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("new_session_cnt", byte_cnt, 0);

        // Streaming 0..255, back to back
        n = 0;
        for (int i = 0; i < 256; i++) begin
            do_read(25'(i), wc, rc, aok);
            if (wc != 3 || ioctl_din !== 8'(i + 8'h11)) begin
                n++;
                if (n <= 4)
                    $display("FAIL stream_byte addr=%0d actual=0x%0h/%0d required=0x%0h/3",
                             i, ioctl_din, wc, 8'(i + 8'h11));
            end
        end
        checks++;
        if (n != 0) failures++;
        chk("stream_byte_cnt", byte_cnt, 256);
        @(negedge clk_sys);

        // Strobes while busy and on the return-to-idle edge are ignored.
        ioctl_addr = 25'h0042;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("busy_req_issued", mem_req, 1);
        @(negedge clk_sys);
        ioctl_addr = 25'h0077;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("busy_din", {ioctl_wait, ioctl_din}, {1'b0, 8'h53});
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ioctl_wait || mem_req) flag = 1'b0;
            @(negedge clk_sys);
        end
        chk("busy_strobe_ignored", flag, 1);
        chk("busy_byte_cnt", byte_cnt, 257);

        // Reset in REQ
        mem_gnt    = 1'b0;
        ioctl_addr = 25'h0200;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("rst_in_req_state", {mem_req, ioctl_wait}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            {ioctl_din, ioctl_wait, mem_req, mem_addr, byte_cnt, upload_done}, 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        mem_gnt = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rst_stays_idle", {ioctl_wait, mem_req}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
